// File: rtl/mem_bus_responder_pkg.sv
// mem_bus_pkg
//   Shared types and helpers for the memory-port responder: funct3 access
//   sizes, MMIO register offsets, responder FSM states, and the lane
//   steering functions used for sub-word loads and stores.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } size_e;

    localparam logic [7:0] MMIO_LED    = 8'h00;
    localparam logic [7:0] MMIO_RGB    = 8'h04;
    localparam logic [7:0] MMIO_MICROS = 8'h08;
    localparam logic [7:0] MMIO_MILLIS = 8'h0C;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    // Byte lanes touched by an access; undefined funct3 codes act as words.
    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: return 4'b0001 << a;
            F3_H, F3_HU: return a[1] ? 4'b1100 : 4'b0011;
            default:     return 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data across lanes; byte enables pick the lane.
    function automatic logic [31:0] store_align(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            F3_B, F3_BU: return {4{wd[7:0]}};
            F3_H, F3_HU: return {2{wd[15:0]}};
            default:     return wd;
        endcase
    endfunction

    // Pull the addressed lane out of a word and sign/zero-extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] w);
        logic [31:0] sh;
        logic [15:0] h;
        sh = w >> {a, 3'b000};
        h  = a[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    return {{24{sh[7]}}, sh[7:0]};
            F3_BU:   return {24'b0, sh[7:0]};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'b0, h};
            default: return w;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_responder_mmio_timer_pwm.sv
// mmio_timer_pwm
//   MMIO peripheral block: LED and RGB duty registers, free-running
//   MICROS/MILLIS timers and an 8-bit PWM counter driving the LED pins.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en             commit a write this cycle
//   off               word offset within the MMIO window (byte offset [7:2])
//   be                byte enables for lanes 0..2 (lane 3 has no storage)
//   wd                lane-aligned write data, lanes 0..2
//   rd_data           register read value for off (combinational)
//   led, red, green, blue   active-high outputs
import mem_bus_pkg::*;

module mmio_timer_pwm #(
    parameter int CLK_HZ = 12_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [5:0]  off,
    input  logic [2:0]  be,
    input  logic [23:0] wd,
    output logic [31:0] rd_data,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam int US_DIV = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
    localparam int PW     = (US_DIV > 1) ? $clog2(US_DIV) : 1;

    logic [PW-1:0] us_pre;
    logic [9:0]    ms_pre;
    logic [31:0]   micros;
    logic [31:0]   millis;
    logic [7:0]    pwm_cnt;
    logic          led_q;
    logic [7:0]    duty_r;
    logic [7:0]    duty_g;
    logic [7:0]    duty_b;

    // Timers, PWM counter and writable registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            us_pre  <= '0;
            ms_pre  <= '0;
            micros  <= '0;
            millis  <= '0;
            pwm_cnt <= '0;
            led_q   <= 1'b0;
            duty_r  <= '0;
            duty_g  <= '0;
            duty_b  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            // millis advances on the same edge that completes its 1000th micros tick
            if (us_pre == PW'(US_DIV - 1)) begin
                us_pre <= '0;
                micros <= micros + 32'd1;
                if (ms_pre == 10'd999) begin
                    ms_pre <= '0;
                    millis <= millis + 32'd1;
                end else begin
                    ms_pre <= ms_pre + 10'd1;
                end
            end else begin
                us_pre <= us_pre + PW'(1);
            end
            if (wr_en && off == MMIO_LED[7:2] && be[0]) begin
                led_q <= wd[0];
            end
            if (wr_en && off == MMIO_RGB[7:2]) begin
                if (be[0]) duty_r <= wd[7:0];
                if (be[1]) duty_g <= wd[15:8];
                if (be[2]) duty_b <= wd[23:16];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (off)
            MMIO_LED[7:2]:    rd_data = {31'b0, led_q};
            MMIO_RGB[7:2]:    rd_data = {8'b0, duty_b, duty_g, duty_r};
            MMIO_MICROS[7:2]: rd_data = micros;
            MMIO_MILLIS[7:2]: rd_data = millis;
            default:          rd_data = '0;
        endcase
    end

    assign led   = led_q;
    assign red   = pwm_cnt < duty_r;
    assign green = pwm_cnt < duty_g;
    assign blue  = pwm_cnt < duty_b;

endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder
//   Responder for the core's memory port. Captures a read or write request
//   in IDLE, waits WAIT_STATES cycles, then answers with a one-cycle
//   mem_ready pulse. Backed by byte-lane block RAM plus an MMIO window.
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   mem_read, write_mem         request strobes, held until mem_ready
//   funct3                      access size / signedness
//   read_address, write_address byte addresses for reads / writes
//   write_data                  right-aligned store data
//   read_data                   extended load result, held between reads
//   mem_ready                   one-cycle completion pulse
//   led, red, green, blue       LED / PWM outputs
import mem_bus_pkg::*;

module mem_bus_responder #(
    parameter int          MEM_WORDS   = 2048,
    parameter int          WAIT_STATES = 1,
    parameter int          CLK_HZ      = 12_000_000,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        write_mem,
    input  logic [2:0]  funct3,
    input  logic [31:0] read_address,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam int         AW      = $clog2(MEM_WORDS);
    localparam logic [3:0] WS_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_e        state;
    state_e        state_nx;
    logic [3:0]    wcnt;
    logic          op_wr;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    f3_q;
    logic [31:0]   rdata_hold;
    logic          req;
    logic          is_mmio;
    logic [3:0]    be_q;
    logic [31:0]   wdata_al;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram_q;
    logic [31:0]   mmio_rdata;
    logic [31:0]   load_val;
    logic          ram_we;
    logic          mmio_we;
    logic          rd_resp;

    assign req = write_mem | mem_read;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (req) state_nx = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (wcnt == WS_LAST) state_nx = S_RESP;
            S_RESP: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Control: FSM, wait counter, held read result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            rdata_hold <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= (state == S_WAIT) ? wcnt + 4'd1 : 4'd0;
            if (rd_resp) rdata_hold <= load_val;
        end
    end

    // Request capture; a write wins over a simultaneous read
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            op_wr   <= write_mem;
            addr_q  <= write_mem ? write_address : read_address;
            f3_q    <= funct3;
            wdata_q <= write_data;
        end
    end

    assign is_mmio  = addr_q[31:8] == MMIO_BASE[31:8];
    assign be_q     = byte_enable(f3_q, addr_q[1:0]);
    assign wdata_al = store_align(f3_q, wdata_q);
    assign ram_we   = (state == S_RESP) && op_wr && !is_mmio;
    assign mmio_we  = (state == S_RESP) && op_wr && is_mmio;
    assign rd_resp  = (state == S_RESP) && !op_wr;

    // RAM is read with the live address at capture so data is ready even with
    // zero wait states; afterwards the latched address keeps the output stable.
    assign ram_idx = (state == S_IDLE)
                   ? (write_mem ? write_address[AW+1:2] : read_address[AW+1:2])
                   : addr_q[AW+1:2];

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] mem [MEM_WORDS];
        logic [7:0] q;
        always_ff @(posedge clk) begin
            if (ram_we && be_q[l]) mem[ram_idx] <= wdata_al[8*l +: 8];
            q <= mem[ram_idx];
        end
        assign ram_q[8*l +: 8] = q;
    end

    mmio_timer_pwm #(
        .CLK_HZ (CLK_HZ)
    ) u_mmio (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (mmio_we),
        .off     (addr_q[7:2]),
        .be      (be_q[2:0]),
        .wd      (wdata_al[23:0]),
        .rd_data (mmio_rdata),
        .led     (led),
        .red     (red),
        .green   (green),
        .blue    (blue)
    );

    // Response: load result is live during RESP, then held until the next read
    assign load_val  = load_extract(f3_q, addr_q[1:0], is_mmio ? mmio_rdata : ram_q);
    assign read_data = rd_resp ? load_val : rdata_hold;
    assign mem_ready = state == S_RESP;

endmodule
